// File: rtl/delay_timer_arbiter_pkg.sv
// Shared definitions for the delay timer arbiter.
// Holds the FSM state encoding used by the top level. The encodings are fixed
// so that any debug tooling that decodes the state register sees stable values.
package delay_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_timer_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Picks the first set request bit, starting the search at ptr and wrapping
// modulo NREQ. Reusable by any arbiter that keeps its own rotating pointer.
// Ports:
//   req    in   NREQ  request vector
//   ptr    in   PW    index where the search starts
//   winner out  NREQ  one-hot winner, all zero when nothing is requested
//   index  out  PW    index of the winner (0 when invalid)
//   valid  out  1     high when any request bit is set
module delay_timer_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   index,
  output logic            valid
);

  logic [PW:0] w_dist;
  logic [PW:0] w_bestDist;

  // Each set bit is ranked by its distance from ptr going upward with wrap;
  // the smallest distance wins. The extra bit in w_dist holds i+NREQ before
  // the subtraction, so the wrap never overflows.
  always_comb begin
    winner     = '0;
    index      = '0;
    valid      = 1'b0;
    w_dist     = '0;
    w_bestDist = '1;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) >= ptr) begin
        w_dist = (PW+1)'(i) - {1'b0, ptr};
      end else begin
        w_dist = (PW+1)'(i) + (PW+1)'(NREQ) - {1'b0, ptr};
      end
      if (req[i] && (!valid || (w_dist < w_bestDist))) begin
        valid      = 1'b1;
        w_bestDist = w_dist;
        index      = PW'(i);
        winner     = '0;
        winner[i]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shares one tick-driven delay counter among NREQ requesters.
// A requester raises req[i] with a delay in ticks on delay[i*DW +: DW]; the
// counter is granted round-robin, counts divider strobes, and done[i] pulses
// once when the delay expires. div_en runs the divider only while counting.
// Ports:
//   clkin   in   1        system clock, all logic on posedge
//   reset   in   1        synchronous active-high reset
//   tick    in   1        one-cycle strobe from the clock divider
//   req     in   NREQ     level request per requester
//   delay   in   NREQ*DW  packed per-requester delays
//   div_en  out  1        enable to the divider
//   busy    out  1        high whenever the FSM is not idle
//   grant   out  NREQ     one-hot owner of the counter
//   done    out  NREQ     one-cycle pulse to the owner at expiry
module delay_timer_arbiter
  import delay_timer_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             tick,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] delay,
  output logic             div_en,
  output logic             busy,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done
);

  localparam int PW = $clog2(NREQ);

  state_t          r_state;
  logic [DW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_divEn;
  logic            r_busy;

  state_t          w_stateNext;
  logic [DW-1:0]   w_cntNext;
  logic [PW-1:0]   w_ptrNext;
  logic [PW-1:0]   w_ownerNext;
  logic [NREQ-1:0] w_grantNext;
  logic [NREQ-1:0] w_doneNext;
  logic            w_divEnNext;
  logic            w_busyNext;

  logic [NREQ-1:0] w_pickOnehot;
  logic [PW-1:0]   w_pickIdx;
  logic            w_pickValid;
  logic [DW-1:0]   w_delaySel;
  logic [PW-1:0]   w_ptrAfter;
  logic            w_ownerReq;

  delay_timer_arbiter_rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .winner(w_pickOnehot),
    .index (w_pickIdx),
    .valid (w_pickValid)
  );

  // Delay of the arbitration winner, captured only at grant time.
  always_comb begin
    w_delaySel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pickIdx == PW'(i)) begin
        w_delaySel = delay[i*DW +: DW];
      end
    end
  end

  assign w_ownerReq = |(req & r_grant);

  // Next state and next values of every registered output. A delay of zero
  // still takes one COUNT cycle so the grant is visible before done, but the
  // divider is never enabled for it. Finishing clears grant, div_en and cnt
  // in the same edge that raises done, and moves the pointer past the owner.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_ptrNext   = r_ptr;
    w_ownerNext = r_owner;
    w_grantNext = r_grant;
    w_doneNext  = '0;
    w_divEnNext = r_divEn;
    w_busyNext  = r_busy;
    w_ptrAfter  = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;

    case (r_state)
      S_IDLE: begin
        w_grantNext = '0;
        w_divEnNext = 1'b0;
        w_busyNext  = 1'b0;
        if (w_pickValid) begin
          w_stateNext = S_COUNT;
          w_grantNext = w_pickOnehot;
          w_ownerNext = w_pickIdx;
          w_cntNext   = w_delaySel;
          w_divEnNext = (w_delaySel != '0);
          w_busyNext  = 1'b1;
        end
      end
      S_COUNT: begin
        if (!w_ownerReq) begin
          w_stateNext = S_IDLE;
          w_grantNext = '0;
          w_divEnNext = 1'b0;
          w_busyNext  = 1'b0;
          w_cntNext   = '0;
          w_ptrNext   = w_ptrAfter;
        end else if ((r_cnt == '0) || (tick && (r_cnt == DW'(1)))) begin
          w_stateNext = S_DONE;
          w_doneNext  = r_grant;
          w_grantNext = '0;
          w_divEnNext = 1'b0;
          w_cntNext   = '0;
          w_ptrNext   = w_ptrAfter;
        end else if (tick) begin
          w_cntNext = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
        w_busyNext  = 1'b0;
      end
      default: begin
        w_stateNext = S_IDLE;
        w_grantNext = '0;
        w_divEnNext = 1'b0;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any count without a done.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_divEn <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_ptr   <= w_ptrNext;
      r_owner <= w_ownerNext;
      r_grant <= w_grantNext;
      r_done  <= w_doneNext;
      r_divEn <= w_divEnNext;
      r_busy  <= w_busyNext;
    end
  end

  assign div_en = r_divEn;
  assign busy   = r_busy;
  assign grant  = r_grant;
  assign done   = r_done;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed self-checking bench for delay_timer_arbiter (NREQ=4, DW=8).
// The divider strobe is modelled by the bench: one tick every 10 clkin.
module tb_delay_timer_arbiter;

  logic        clkin;
  logic        reset;
  logic        tick;
  logic [3:0]  req;
  logic [31:0] delay;
  logic        div_en;
  logic        busy;
  logic [3:0]  grant;
  logic [3:0]  done;

  int checkCount;
  int errorCount;
  int tickPhase;
  logic sampledTick;

  delay_timer_arbiter #(
    .NREQ(4),
    .DW  (8)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .tick  (tick),
    .req   (req),
    .delay (delay),
    .div_en(div_en),
    .busy  (busy),
    .grant (grant),
    .done  (done)
  );

  // Free-running system clock, 10 ns period.
  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  // Compares one observed value against its expected value and tallies it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Sets the request vector and the four packed delays.
  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d3,
                               input logic [7:0] d2, input logic [7:0] d1,
                               input logic [7:0] d0);
    req   = r;
    delay = {d3, d2, d1, d0};
  endtask

  // Advances one clock. Afterwards sampledTick is the tick the DUT saw at
  // that edge, and tick is set up for the next edge.
  task automatic cycle();
    @(posedge clkin);
    #1;
    sampledTick = tick;
    tickPhase   = (tickPhase == 9) ? 0 : tickPhase + 1;
    tick        = (tickPhase == 9);
  endtask

  // Holds reset for two cycles, checks every output is cleared, then releases.
  task automatic applyReset(input string tag);
    reset = 1'b1;
    req   = '0;
    cycle();
    cycle();
    checkOutput({tag, ".grant"},  grant,  0);
    checkOutput({tag, ".done"},   done,   0);
    checkOutput({tag, ".div_en"}, div_en, 0);
    checkOutput({tag, ".busy"},   busy,   0);
    reset = 1'b0;
  endtask

  // Runs until k ticks have been seen by the DUT while it counts.
  task automatic waitTicks(input int k, input string tag);
    int t;
    int g;
    int badDone;
    t = 0;
    g = 0;
    badDone = 0;
    while (t < k && g < 200) begin
      cycle();
      g++;
      if (sampledTick) t++;
      if (done != 0) badDone++;
    end
    checkOutput({tag, ".ticks"},  t, k);
    checkOutput({tag, ".noDone"}, badDone, 0);
  endtask

  // DUT must be idle with requests present. Expects the grant on the next
  // edge, grant/div_en held and no done until the n-th tick, then done on
  // the edge that consumed that tick (or one cycle after grant for n=0).
  task automatic runGrant(input logic [3:0] expGrant, input int n,
                          input string tag);
    int ticks;
    int guard;
    int bad;
    cycle();
    checkOutput({tag, ".grant"},  grant,  expGrant);
    checkOutput({tag, ".div_en"}, div_en, (n != 0) ? 1 : 0);
    ticks = 0;
    guard = 0;
    bad   = 0;
    while (ticks < n && guard < 3000) begin
      cycle();
      guard++;
      if (sampledTick) ticks++;
      if (ticks < n && (grant !== expGrant || div_en !== 1'b1 || done !== 4'b0))
        bad++;
    end
    if (n == 0) cycle();
    checkOutput({tag, ".hold"},      bad,    0);
    checkOutput({tag, ".ticks"},     ticks,  n);
    checkOutput({tag, ".done"},      done,   expGrant);
    checkOutput({tag, ".grantClr"},  grant,  0);
    checkOutput({tag, ".divEnClr"},  div_en, 0);
    checkOutput({tag, ".busyDone"},  busy,   1);
  endtask

  // Directed test sequence.
  initial begin
    logic [3:0] order [5];
    checkCount  = 0;
    errorCount  = 0;
    tickPhase   = 0;
    tick        = 1'b0;
    sampledTick = 1'b0;
    reset       = 1'b1;
    req         = '0;
    delay       = '0;

    // Single requester, delay of 3 ticks.
    applyReset("t1.rst");
    applyStimulus(4'b0001, 8'd0, 8'd0, 8'd0, 8'd3);
    runGrant(4'b0001, 3, "t1");
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    cycle();
    checkOutput("t1.idle.busy", busy, 0);
    checkOutput("t1.idle.done", done, 0);

    // All four held with delay 1: strict rotation from pointer 0.
    applyReset("t2.rst");
    applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        cycle();
        checkOutput("t2.idle.busy", busy, 0);
      end
      runGrant(order[i], 1, "t2");
    end

    // Zero delay: grant then done next cycle, divider never enabled.
    applyStimulus(4'b0100, 8'd1, 8'd0, 8'd1, 8'd1);
    cycle();
    runGrant(4'b0100, 0, "t3");

    // Abort after two ticks: no done, pointer moves past owner 1 to 2.
    applyStimulus(4'b0010, 8'd1, 8'd1, 8'd5, 8'd1);
    cycle();
    checkOutput("t4.idle.busy", busy, 0);
    cycle();
    checkOutput("t4.grant",  grant,  4'b0010);
    checkOutput("t4.div_en", div_en, 1);
    waitTicks(2, "t4.wait");
    applyStimulus(4'b0000, 8'd1, 8'd1, 8'd5, 8'd1);
    cycle();
    checkOutput("t4.abort.grant",  grant,  0);
    checkOutput("t4.abort.done",   done,   0);
    checkOutput("t4.abort.busy",   busy,   0);
    checkOutput("t4.abort.div_en", div_en, 0);
    cycle();
    checkOutput("t4.abort.noDone", done, 0);
    // Search starts at 2, so requester 2 beats 0 and 1; then the pointer is 3
    // and requester 0 is next.
    applyStimulus(4'b0111, 8'd1, 8'd1, 8'd1, 8'd1);
    runGrant(4'b0100, 1, "t4b");
    cycle();
    runGrant(4'b0001, 1, "t4c");

    // Reset while counting (cnt=4), with the pointer sitting at 1.
    applyStimulus(4'b1000, 8'd6, 8'd1, 8'd1, 8'd1);
    cycle();
    cycle();
    checkOutput("t5.grant", grant, 4'b1000);
    waitTicks(2, "t5.wait");
    reset = 1'b1;
    cycle();
    checkOutput("t5.rst.grant",  grant,  0);
    checkOutput("t5.rst.done",   done,   0);
    checkOutput("t5.rst.div_en", div_en, 0);
    checkOutput("t5.rst.busy",   busy,   0);
    reset = 1'b0;
    // Pointer back at 0, so requester 0 wins first.
    applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
    runGrant(4'b0001, 1, "t5ptr");

    // Maximum delay: exactly 255 ticks, no wrap.
    applyStimulus(4'b0010, 8'd1, 8'd1, 8'd255, 8'd1);
    cycle();
    runGrant(4'b0010, 255, "t6");
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    cycle();
    cycle();
    checkOutput("end.busy",  busy,  0);
    checkOutput("end.grant", grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
